// File: rtl/rdma_wr_route_tagger.sv
// Queues (vfid, route_id, beats) per write request and stamps each data beat with registered tid/tdest.
// Optional length checking and DRAIN recovery are enabled by defining RDMA_WR_TAG_LEN_CHECK_EN.
module rdma_wr_route_tagger #(
   parameter int TAG_DEPTH    = 16,
   parameter int VFID_BITS    = 4,
   parameter int ROUTE_BITS   = 14,
   parameter int LEN_BITS     = 28,
   parameter int AXI_NET_BITS = 512
) (
   input  logic                          i_aclk,
   input  logic                          i_aresetn,
   input  logic                          i_s_rq_wr_valid,
   output logic                          o_s_rq_wr_ready,
   input  logic [VFID_BITS-1:0]          i_s_rq_wr_vfid,
   input  logic [ROUTE_BITS-1:0]         i_s_rq_wr_route_id,
   input  logic [LEN_BITS-1:0]           i_s_rq_wr_len,
   output logic                          o_m_rq_wr_valid,
   input  logic                          i_m_rq_wr_ready,
   output logic [VFID_BITS-1:0]          o_m_rq_wr_vfid,
   output logic [ROUTE_BITS-1:0]         o_m_rq_wr_route_id,
   output logic [LEN_BITS-1:0]           o_m_rq_wr_len,
   input  logic                          i_s_axis_wr_tvalid,
   output logic                          o_s_axis_wr_tready,
   input  logic [AXI_NET_BITS-1:0]       i_s_axis_wr_tdata,
   input  logic [AXI_NET_BITS/8-1:0]     i_s_axis_wr_tkeep,
   input  logic                          i_s_axis_wr_tlast,
   output logic                          o_m_axis_wr_tvalid,
   input  logic                          i_m_axis_wr_tready,
   output logic [AXI_NET_BITS-1:0]       o_m_axis_wr_tdata,
   output logic [AXI_NET_BITS/8-1:0]     o_m_axis_wr_tkeep,
   output logic                          o_m_axis_wr_tlast,
   output logic [VFID_BITS-1:0]          o_m_axis_wr_tid,
   output logic [ROUTE_BITS-1:0]         o_m_axis_wr_tdest,
   output logic                          o_err_len,
   output logic [15:0]                   o_err_cnt,
   output logic [$clog2(TAG_DEPTH):0]    o_tag_occ
);

   localparam int PTR_BITS = $clog2(TAG_DEPTH);
   localparam int OCC_BITS = PTR_BITS + 1;
`ifdef RDMA_WR_TAG_LEN_CHECK_EN
   localparam int CNT_BITS = LEN_BITS - 6;
`endif

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } state_t;

   state_t                 r_state;
   state_t                 w_stateNext;
   logic [PTR_BITS-1:0]    r_wrPtr;
   logic [PTR_BITS-1:0]    r_rdPtr;
   logic [OCC_BITS-1:0]    r_occ;
   logic [VFID_BITS-1:0]   r_fifoVfid  [TAG_DEPTH];
   logic [ROUTE_BITS-1:0]  r_fifoRoute [TAG_DEPTH];
   logic [VFID_BITS-1:0]   r_tagVfid;
   logic [ROUTE_BITS-1:0]  r_tagRoute;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_beatHs;
   logic                   w_burstEnd;
   logic                   w_toDrain;
   logic                   w_sTready;
   logic                   w_mTvalid;
   logic                   w_mTlast;
`ifdef RDMA_WR_TAG_LEN_CHECK_EN
   logic [CNT_BITS-1:0]    r_fifoBeats [TAG_DEPTH];
   logic [CNT_BITS-1:0]    r_cnt;
   logic [CNT_BITS-1:0]    w_beats;
   logic [15:0]            r_errCnt;
   logic                   w_errLen;
`endif

   assign w_full  = (r_occ == OCC_BITS'(TAG_DEPTH));
   assign w_empty = (r_occ == '0);

   assign o_m_rq_wr_valid    = i_aresetn & i_s_rq_wr_valid & ~w_full;
   assign o_s_rq_wr_ready    = i_aresetn & i_m_rq_wr_ready & ~w_full;
   assign o_m_rq_wr_vfid     = i_s_rq_wr_vfid;
   assign o_m_rq_wr_route_id = i_s_rq_wr_route_id;
   assign o_m_rq_wr_len      = i_s_rq_wr_len;
   assign w_push = i_s_rq_wr_valid & o_s_rq_wr_ready & (i_s_rq_wr_len != '0);

`ifdef RDMA_WR_TAG_LEN_CHECK_EN
   // A max-length request rounds to 2^CNT_BITS beats, which stores as 0; the down-counter wraps and still ends on the right beat.
   assign w_beats = CNT_BITS'(({1'b0, i_s_rq_wr_len} + (LEN_BITS + 1)'(63)) >> 6);
`endif

   always_ff @(posedge i_aclk) begin
      if (w_push) begin
         r_fifoVfid[r_wrPtr]  <= i_s_rq_wr_vfid;
         r_fifoRoute[r_wrPtr] <= i_s_rq_wr_route_id;
`ifdef RDMA_WR_TAG_LEN_CHECK_EN
         r_fifoBeats[r_wrPtr] <= w_beats;
`endif
      end
   end

   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_occ   <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PTR_BITS'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PTR_BITS'(1);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_BITS'(1);
            2'b01:   r_occ <= r_occ - OCC_BITS'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_state    <= IDLE;
         r_tagVfid  <= '0;
         r_tagRoute <= '0;
`ifdef RDMA_WR_TAG_LEN_CHECK_EN
         r_cnt      <= '0;
`endif
      end else begin
         r_state <= w_stateNext;
         if (w_pop) begin
            r_tagVfid  <= r_fifoVfid[r_rdPtr];
            r_tagRoute <= r_fifoRoute[r_rdPtr];
`ifdef RDMA_WR_TAG_LEN_CHECK_EN
            r_cnt      <= r_fifoBeats[r_rdPtr];
         end else if (w_beatHs) begin
            r_cnt      <= r_cnt - CNT_BITS'(1);
`endif
         end
      end
   end

   // Reset gates every handshake so nothing leaks downstream while state is being cleared.
   always_comb begin
      w_stateNext = r_state;
      w_pop       = 1'b0;
      w_sTready   = 1'b0;
      w_mTvalid   = 1'b0;
      w_mTlast    = 1'b0;
      w_beatHs    = 1'b0;
      w_burstEnd  = 1'b0;
      w_toDrain   = 1'b0;
`ifdef RDMA_WR_TAG_LEN_CHECK_EN
      w_errLen    = 1'b0;
`endif
      if (i_aresetn) begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_stateNext = STREAM;
               end
            end
            STREAM: begin
               w_mTvalid = i_s_axis_wr_tvalid;
               w_sTready = i_m_axis_wr_tready;
               w_beatHs  = i_s_axis_wr_tvalid & i_m_axis_wr_tready;
`ifdef RDMA_WR_TAG_LEN_CHECK_EN
               w_mTlast  = (r_cnt == CNT_BITS'(1)) | i_s_axis_wr_tlast;
               if (w_beatHs) begin
                  if (r_cnt == CNT_BITS'(1)) begin
                     w_burstEnd = 1'b1;
                     if (!i_s_axis_wr_tlast) begin
                        w_errLen  = 1'b1;
                        w_toDrain = 1'b1;
                     end
                  end else if (i_s_axis_wr_tlast) begin
                     w_errLen   = 1'b1;
                     w_burstEnd = 1'b1;
                  end
               end
`else
               w_mTlast   = i_s_axis_wr_tlast;
               w_burstEnd = w_beatHs & i_s_axis_wr_tlast;
`endif
            end
            DRAIN: begin
               w_sTready  = 1'b1;
               w_burstEnd = i_s_axis_wr_tvalid & i_s_axis_wr_tlast;
            end
            default: w_stateNext = IDLE;
         endcase
         if (w_toDrain) begin
            w_stateNext = DRAIN;
         end else if (w_burstEnd) begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_stateNext = STREAM;
            end else begin
               w_stateNext = IDLE;
            end
         end
      end
   end

   assign o_s_axis_wr_tready = w_sTready;
   assign o_m_axis_wr_tvalid = w_mTvalid;
   assign o_m_axis_wr_tlast  = w_mTlast;
   assign o_m_axis_wr_tdata  = i_s_axis_wr_tdata;
   assign o_m_axis_wr_tkeep  = i_s_axis_wr_tkeep;
   assign o_m_axis_wr_tid    = r_tagVfid;
   assign o_m_axis_wr_tdest  = r_tagRoute;
   assign o_tag_occ          = r_occ;

`ifdef RDMA_WR_TAG_LEN_CHECK_EN
   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_errCnt <= '0;
      end else if (w_errLen && (r_errCnt != 16'hFFFF)) begin
         r_errCnt <= r_errCnt + 16'd1;
      end
   end

   assign o_err_len = w_errLen;
   assign o_err_cnt = r_errCnt;
`else
   assign o_err_len = 1'b0;
   assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rdma_wr_route_tagger.sv
// Directed plus randomized bench for rdma_wr_route_tagger, checked against a queue-based tag model.
// Length-mismatch steps are compiled only when RDMA_WR_TAG_LEN_CHECK_EN is defined.
module tb_rdma_wr_route_tagger;

   localparam int WAIT_LIMIT = 50;

   typedef struct {
      logic [3:0]  vfid;
      logic [13:0] route;
      int          beats;
   } tagT;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          sValid, sReady, mValid, mReady;
   logic [3:0]    sVfid, mVfid;
   logic [13:0]   sRoute, mRoute;
   logic [27:0]   sLen, mLen;
   logic          sTvalid, sTready, sTlast;
   logic [511:0]  sTdata, mTdata;
   logic [63:0]   sTkeep, mTkeep;
   logic          mTvalid, mTready, mTlast;
   logic [3:0]    mTid;
   logic [13:0]   mTdest;
   logic          errLen;
   logic [15:0]   errCnt;
   logic [4:0]    tagOcc;

   int            assertCount = 0;
   int            failCount   = 0;
   int            expErrCnt   = 0;
   tagT           tagQ[$];

   rdma_wr_route_tagger dut (
      .i_aclk             (aclk),
      .i_aresetn          (aresetn),
      .i_s_rq_wr_valid    (sValid),
      .o_s_rq_wr_ready    (sReady),
      .i_s_rq_wr_vfid     (sVfid),
      .i_s_rq_wr_route_id (sRoute),
      .i_s_rq_wr_len      (sLen),
      .o_m_rq_wr_valid    (mValid),
      .i_m_rq_wr_ready    (mReady),
      .o_m_rq_wr_vfid     (mVfid),
      .o_m_rq_wr_route_id (mRoute),
      .o_m_rq_wr_len      (mLen),
      .i_s_axis_wr_tvalid (sTvalid),
      .o_s_axis_wr_tready (sTready),
      .i_s_axis_wr_tdata  (sTdata),
      .i_s_axis_wr_tkeep  (sTkeep),
      .i_s_axis_wr_tlast  (sTlast),
      .o_m_axis_wr_tvalid (mTvalid),
      .i_m_axis_wr_tready (mTready),
      .o_m_axis_wr_tdata  (mTdata),
      .o_m_axis_wr_tkeep  (mTkeep),
      .o_m_axis_wr_tlast  (mTlast),
      .o_m_axis_wr_tid    (mTid),
      .o_m_axis_wr_tdest  (mTdest),
      .o_err_len          (errLen),
      .o_err_cnt          (errCnt),
      .o_tag_occ          (tagOcc)
   );

   always #5 aclk = ~aclk;

   // Hard stop in case a bounded wait is somehow bypassed.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkData(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Send one write request and record its tag in the model when it carries data.
   task automatic applyStimulus(input logic [3:0] vfid, input logic [13:0] route, input logic [27:0] len);
      int  w;
      tagT t;
      @(negedge aclk);
      sValid = 1'b1;
      sVfid  = vfid;
      sRoute = route;
      sLen   = len;
      mReady = 1'b1;
      #1;
      w = 0;
      while (sReady !== 1'b1 && w < WAIT_LIMIT) begin
         @(negedge aclk);
         #1;
         w++;
      end
      checkOutput("rqReady", sReady, 1);
      checkOutput("rqValid", mValid, 1);
      checkOutput("rqVfid", mVfid, vfid);
      checkOutput("rqRoute", mRoute, route);
      checkOutput("rqLen", mLen, len);
      @(posedge aclk);
      if (len != 0) begin
         t.vfid  = vfid;
         t.route = route;
         t.beats = (int'(len) + 63) / 64;
         tagQ.push_back(t);
      end
      #1;
      sValid = 1'b0;
      mReady = 1'b0;
   endtask

   // Drive nIn beats (tlast on beat tlastAt) for the model's head tag; later beats must not wait.
   task automatic runBurst(input int nIn, input int tlastAt, input bit firstOfBatch);
      tagT           t;
      int            w;
      logic [511:0]  d;
      logic [63:0]   k;
      t = tagQ.pop_front();
      for (int b = 1; b <= nIn; b++) begin
         if (!(firstOfBatch && b == 1) && $urandom_range(0, 3) == 0) begin
            @(negedge aclk);
            sTvalid = 1'b1;
            mTready = 1'b0;
            #1;
            checkOutput("stallReady", sTready, 0);
            checkOutput("stallValid", mTvalid, 1);
         end
         @(negedge aclk);
         for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
         k = {$urandom(), $urandom()};
         sTvalid = 1'b1;
         sTdata  = d;
         sTkeep  = k;
         sTlast  = (b == tlastAt);
         mTready = 1'b1;
         #1;
         w = 0;
         while (sTready !== 1'b1 && w < WAIT_LIMIT) begin
            @(negedge aclk);
            #1;
            w++;
         end
         checkOutput("beatReady", sTready, 1);
         if (!(firstOfBatch && b == 1)) checkOutput("bubble", w, 0);
         checkOutput("tvalid", mTvalid, 1);
         checkOutput("tid", mTid, t.vfid);
         checkOutput("tdest", mTdest, t.route);
         checkOutput("tlast", mTlast, (b == tlastAt));
         checkData("tdata", mTdata, d);
         checkOutput("tkeep", mTkeep, k);
         checkOutput("errLen", errLen, 0);
         @(posedge aclk);
         #1;
         sTvalid = 1'b0;
         sTlast  = 1'b0;
         mTready = 1'b0;
      end
   endtask

   // After traffic settles: FIFO empty, FSM idle so data is blocked, error count as modelled.
   task automatic checkIdle(input string tag);
      @(negedge aclk);
      sTvalid = 1'b1;
      mTready = 1'b1;
      #1;
      checkOutput({tag, "Occ"}, tagOcc, 0);
      checkOutput({tag, "Ready"}, sTready, 0);
      checkOutput({tag, "Valid"}, mTvalid, 0);
      checkOutput({tag, "ErrCnt"}, errCnt, expErrCnt);
      sTvalid = 1'b0;
      mTready = 1'b0;
   endtask

`ifdef RDMA_WR_TAG_LEN_CHECK_EN
   // The burst delivers min(beats, tlastAt) beats; input beats after that are swallowed up to tlast.
   task automatic runMismatch(input int tlastAt);
      tagT t;
      int  e;
      int  w;
      bit  mis;
      t   = tagQ.pop_front();
      e   = (t.beats < tlastAt) ? t.beats : tlastAt;
      mis = (t.beats != tlastAt);
      for (int b = 1; b <= tlastAt; b++) begin
         @(negedge aclk);
         sTvalid = 1'b1;
         sTdata  = {16{$urandom()}};
         sTkeep  = '1;
         sTlast  = (b == tlastAt);
         mTready = 1'b1;
         #1;
         w = 0;
         while (sTready !== 1'b1 && w < WAIT_LIMIT) begin
            @(negedge aclk);
            #1;
            w++;
         end
         checkOutput("mmReady", sTready, 1);
         if (b <= e) begin
            checkOutput("mmValid", mTvalid, 1);
            checkOutput("mmTid", mTid, t.vfid);
            checkOutput("mmTlast", mTlast, (b == e));
            checkOutput("mmErrLen", errLen, (mis && b == e));
         end else begin
            checkOutput("mmDropValid", mTvalid, 0);
            checkOutput("mmDropErrLen", errLen, 0);
         end
         @(posedge aclk);
         #1;
         sTvalid = 1'b0;
         sTlast  = 1'b0;
         mTready = 1'b0;
      end
      if (mis) expErrCnt++;
      @(negedge aclk);
      #1;
      checkOutput("mmErrCnt", errCnt, expErrCnt);
   endtask
`endif

   initial begin
      int k;
      int nBursts;
      aresetn = 1'b0;
      sValid  = 1'b1;
      mReady  = 1'b1;
      sVfid   = 4'h5;
      sRoute  = 14'h0123;
      sLen    = 28'd64;
      sTvalid = 1'b1;
      sTdata  = '0;
      sTkeep  = '0;
      sTlast  = 1'b1;
      mTready = 1'b1;

      repeat (2) @(posedge aclk);
      @(negedge aclk);
      #1;
      checkOutput("rstRqValid", mValid, 0);
      checkOutput("rstRqReady", sReady, 0);
      checkOutput("rstTready", sTready, 0);
      checkOutput("rstTvalid", mTvalid, 0);
      checkOutput("rstTid", mTid, 0);
      checkOutput("rstTdest", mTdest, 0);
      checkOutput("rstTlast", mTlast, 0);
      checkOutput("rstErrLen", errLen, 0);
      checkOutput("rstErrCnt", errCnt, 0);
      checkOutput("rstOcc", tagOcc, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      sValid  = 1'b0;
      mReady  = 1'b0;
      sTvalid = 1'b0;
      sTlast  = 1'b0;
      mTready = 1'b0;

      $display("[TB] single burst");
      applyStimulus(4'd3, 14'h0155, 28'd256);
      runBurst(4, 4, 1'b1);
      checkIdle("single");

      $display("[TB] back-to-back bursts");
      applyStimulus(4'd1, 14'h0011, 28'd64);
      applyStimulus(4'd2, 14'h0022, 28'd130);
      runBurst(1, 1, 1'b1);
      runBurst(3, 3, 1'b0);
      checkIdle("b2b");

      $display("[TB] full tag FIFO");
      for (int i = 0; i < 17; i++) applyStimulus(4'(i), 14'(i * 7 + 1), 28'd64);
      @(negedge aclk);
      sValid = 1'b1;
      sVfid  = 4'hE;
      sRoute = 14'h3E3E;
      sLen   = 28'd65;
      mReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("fullOcc", tagOcc, 16);
         checkOutput("fullRqReady", sReady, 0);
         checkOutput("fullRqValid", mValid, 0);
         @(negedge aclk);
      end
      runBurst(1, 1, 1'b0);
      @(negedge aclk);
      #1;
      checkOutput("afterPopOcc", tagOcc, 15);
      checkOutput("afterPopRqReady", sReady, 1);
      checkOutput("afterPopRqValid", mValid, 1);
      @(posedge aclk);
      begin
         tagT t;
         t.vfid  = 4'hE;
         t.route = 14'h3E3E;
         t.beats = 2;
         tagQ.push_back(t);
      end
      #1;
      sValid = 1'b0;
      mReady = 1'b0;
      @(negedge aclk);
      #1;
      checkOutput("refillOcc", tagOcc, 16);
      for (int i = 0; i < 16; i++) runBurst(1, 1, 1'b0);
      runBurst(2, 2, 1'b0);
      checkIdle("full");

      $display("[TB] simultaneous push and pop");
      applyStimulus(4'd5, 14'h00AA, 28'd64);
      applyStimulus(4'd6, 14'h00BB, 28'd64);
      @(negedge aclk);
      #1;
      checkOutput("ppOccBefore", tagOcc, 1);
      @(negedge aclk);
      sTvalid = 1'b1;
      sTdata  = {16{32'hA5A5_0001}};
      sTkeep  = '1;
      sTlast  = 1'b1;
      mTready = 1'b1;
      sValid  = 1'b1;
      sVfid   = 4'd7;
      sRoute  = 14'h00CC;
      sLen    = 28'd64;
      mReady  = 1'b1;
      #1;
      checkOutput("ppTready", sTready, 1);
      checkOutput("ppTid", mTid, tagQ[0].vfid);
      checkOutput("ppTlast", mTlast, 1);
      checkOutput("ppRqReady", sReady, 1);
      @(posedge aclk);
      void'(tagQ.pop_front());
      begin
         tagT t;
         t.vfid  = 4'd7;
         t.route = 14'h00CC;
         t.beats = 1;
         tagQ.push_back(t);
      end
      #1;
      sTvalid = 1'b0;
      sTlast  = 1'b0;
      mTready = 1'b0;
      sValid  = 1'b0;
      mReady  = 1'b0;
      @(negedge aclk);
      #1;
      checkOutput("ppOccAfter", tagOcc, 1);
      runBurst(1, 1, 1'b0);
      runBurst(1, 1, 1'b0);
      checkIdle("pushPop");

      $display("[TB] randomized batches");
      for (int batch = 0; batch < 12; batch++) begin
         k = $urandom_range(1, 3);
         for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 7) == 0)
               applyStimulus(4'($urandom_range(0, 15)), 14'($urandom_range(0, 16383)), 28'd0);
            else
               applyStimulus(4'($urandom_range(0, 15)), 14'($urandom_range(0, 16383)), 28'($urandom_range(1, 320)));
         end
         nBursts = tagQ.size();
         for (int i = 0; i < nBursts; i++) runBurst(tagQ[0].beats, tagQ[0].beats, (i == 0));
         checkIdle("rand");
      end

      $display("[TB] reset mid-burst");
      applyStimulus(4'd9, 14'h1234, 28'd256);
      runBurst(1, 0, 1'b1);
      @(negedge aclk);
      aresetn = 1'b0;
      sValid  = 1'b1;
      mReady  = 1'b1;
      sTvalid = 1'b1;
      mTready = 1'b1;
      #1;
      checkOutput("midRstTready", sTready, 0);
      checkOutput("midRstTvalid", mTvalid, 0);
      checkOutput("midRstRqReady", sReady, 0);
      checkOutput("midRstRqValid", mValid, 0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      sValid  = 1'b0;
      mReady  = 1'b0;
      sTvalid = 1'b0;
      mTready = 1'b0;
      tagQ.delete();
      expErrCnt = 0;
      @(negedge aclk);
      #1;
      checkOutput("postRstOcc", tagOcc, 0);
      checkOutput("postRstTid", mTid, 0);
      checkOutput("postRstTdest", mTdest, 0);
      checkOutput("postRstTlast", mTlast, 0);
      checkOutput("postRstErrCnt", errCnt, 0);
      applyStimulus(4'd10, 14'h02AB, 28'd100);
      runBurst(2, 2, 1'b1);
      checkIdle("postRst");

`ifdef RDMA_WR_TAG_LEN_CHECK_EN
      $display("[TB] length mismatch");
      applyStimulus(4'd4, 14'h0010, 28'd128);
      runMismatch(4);
      applyStimulus(4'd4, 14'h0011, 28'd128);
      runMismatch(1);
      applyStimulus(4'd8, 14'h0012, 28'd192);
      runMismatch(3);
      checkIdle("mismatch");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
